// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment codes are active-low, bit order g..a.
package seg7_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        ON    = 1'b1
    } slot_state_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;
    localparam logic [6:0] SEG7_DARK = 7'h7F;

    // Bit i set when nibbles i..7 are all zero; digit 0 is never a leading zero.
    function automatic logic [7:0] lz_mask(input logic [31:0] v);
        logic [7:0] m;
        logic       all_zero;
        m        = 8'h00;
        all_zero = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            all_zero = all_zero & (v[i*4 +: 4] == 4'h0);
            m[i]     = all_zero;
        end
        return m;
    endfunction

endpackage

// File: rtl/hexto7seg.sv
// Combinational hex-nibble to active-low seven-segment (g..a) decoder.
module hexto7seg
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Nibble lookup into the shared segment table.
    always_comb begin
        o_seg = SEG7_DARK;
        case (i_nibble)
            4'h0:    o_seg = SEG_HEX_0;
            4'h1:    o_seg = SEG_HEX_1;
            4'h2:    o_seg = SEG_HEX_2;
            4'h3:    o_seg = SEG_HEX_3;
            4'h4:    o_seg = SEG_HEX_4;
            4'h5:    o_seg = SEG_HEX_5;
            4'h6:    o_seg = SEG_HEX_6;
            4'h7:    o_seg = SEG_HEX_7;
            4'h8:    o_seg = SEG_HEX_8;
            4'h9:    o_seg = SEG_HEX_9;
            4'hA:    o_seg = SEG_HEX_A;
            4'hB:    o_seg = SEG_HEX_B;
            4'hC:    o_seg = SEG_HEX_C;
            4'hD:    o_seg = SEG_HEX_D;
            4'hE:    o_seg = SEG_HEX_E;
            4'hF:    o_seg = SEG_HEX_F;
            default: o_seg = SEG7_DARK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// 8-digit multiplexed seven-segment driver with blanking between slots
// and frame-aligned value updates through a load/ack handshake.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int CLK_DIV      = 100_000,
    parameter int BLANK_CYCLES = 16,
    parameter int NDIGITS      = 8
)
(
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_value,
    input  logic        i_load,
    output logic        o_load_ack,
    input  logic [7:0]  i_dp_mask,
    input  logic [7:0]  i_digit_enable,
    input  logic        i_lz_blank,
    output logic [7:0]  o_digitselect,
    output logic [7:0]  o_segments
);

    localparam int             PW         = $clog2(CLK_DIV + 1);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]  BLANK_LEN  = PW'(BLANK_CYCLES);
    localparam logic [2:0]     DIGIT_LAST = 3'(NDIGITS - 1);

    logic [PW-1:0] r_presc;
    logic [2:0]    r_digit;
    slot_state_e   r_state;
    logic [31:0]   r_shown;
    logic [7:0]    r_shown_dp;
    logic [31:0]   r_shadow;
    logic [7:0]    r_shadow_dp;
    logic          r_pending;
    logic          r_load_ack;
    logic [7:0]    r_digitselect;
    logic [7:0]    r_segments;

    logic [PW-1:0] w_presc_next;
    logic [2:0]    w_digit_next;
    slot_state_e   w_state_next;
    logic          w_slot_wrap;
    logic          w_frame_wrap;
    logic          w_apply;
    logic [3:0]    w_nibble;
    logic [6:0]    w_seg7;
    logic [7:0]    w_lz_mask;
    logic          w_drive;
    logic [7:0]    w_sel_next;
    logic [7:0]    w_seg_next;

    assign w_slot_wrap  = (r_presc == PRESC_LAST);
    assign w_frame_wrap = w_slot_wrap && (r_digit == DIGIT_LAST);
    assign w_apply      = w_frame_wrap && (i_load || r_pending);

    // Prescaler and digit index advance.
    always_comb begin
        w_presc_next = r_presc;
        w_digit_next = r_digit;
        if (w_slot_wrap) begin
            w_presc_next = '0;
            w_digit_next = (r_digit == DIGIT_LAST) ? 3'd0 : r_digit + 3'd1;
        end else begin
            w_presc_next = r_presc + {{(PW-1){1'b0}}, 1'b1};
            w_digit_next = r_digit;
        end
    end

    // Slot FSM next state follows the prescaler position it is about to hold,
    // so a wrap always lands in BLANK.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BLANK:   w_state_next = (w_presc_next < BLANK_LEN) ? BLANK : ON;
            ON:      w_state_next = (w_presc_next < BLANK_LEN) ? BLANK : ON;
            default: w_state_next = BLANK;
        endcase
    end

    // Scan position and slot state registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_presc <= '0;
            r_digit <= 3'd0;
            r_state <= BLANK;
        end else begin
            r_presc <= w_presc_next;
            r_digit <= w_digit_next;
            r_state <= w_state_next;
        end
    end

    // Shadow capture, frame-boundary apply (with same-cycle bypass) and ack.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_shown     <= 32'h0000_0000;
            r_shown_dp  <= 8'h00;
            r_shadow    <= 32'h0000_0000;
            r_shadow_dp <= 8'h00;
            r_pending   <= 1'b0;
            r_load_ack  <= 1'b0;
        end else begin
            r_load_ack <= 1'b0;
            if (w_apply) begin
                if (i_load) begin
                    r_shown    <= i_value;
                    r_shown_dp <= i_dp_mask;
                end else begin
                    r_shown    <= r_shadow;
                    r_shown_dp <= r_shadow_dp;
                end
                r_pending  <= 1'b0;
                r_load_ack <= 1'b1;
            end else if (i_load) begin
                r_shadow    <= i_value;
                r_shadow_dp <= i_dp_mask;
                r_pending   <= 1'b1;
            end else begin
                r_pending <= r_pending;
            end
        end
    end

    assign w_nibble  = r_shown[{r_digit, 2'b00} +: 4];
    assign w_lz_mask = lz_mask(r_shown);
    assign w_drive   = (r_state == ON) && i_digit_enable[r_digit]
                       && !(i_lz_blank && w_lz_mask[r_digit]);

    hexto7seg u_hexto7seg (
        .i_nibble (w_nibble),
        .o_seg    (w_seg7)
    );

    // Output selection for the current scan position.
    always_comb begin
        w_sel_next = SEG_OFF;
        w_seg_next = SEG_OFF;
        if (w_drive) begin
            w_sel_next = ~(8'h01 << r_digit);
            w_seg_next = {~r_shown_dp[r_digit], w_seg7};
        end else begin
            w_sel_next = SEG_OFF;
            w_seg_next = SEG_OFF;
        end
    end

    // Registered pin drivers; reset forces the display dark immediately.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_digitselect <= SEG_OFF;
            r_segments    <= SEG_OFF;
        end else begin
            r_digitselect <= w_sel_next;
            r_segments    <= w_seg_next;
        end
    end

    assign o_digitselect = r_digitselect;
    assign o_segments    = r_segments;
    assign o_load_ack    = r_load_ack;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller at CLK_DIV=4, BLANK_CYCLES=1.
module tb_seg7_scan_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] value;
    logic        load;
    logic        ack;
    logic [7:0]  dp_mask;
    logic [7:0]  digit_enable;
    logic        lz_blank;
    logic [7:0]  sel;
    logic [7:0]  seg;

    int n_cmp  = 0;
    int n_fail = 0;
    int k      = 0;
    int acks;

    typedef struct {
        logic [31:0] value;
        logic [7:0]  dp;
        logic [7:0]  en;
        logic        lz;
        int          dig;
        logic [7:0]  exp_sel;
        logic [7:0]  exp_seg;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    seg7_scan_controller #(
        .CLK_DIV      (4),
        .BLANK_CYCLES (1),
        .NDIGITS      (8)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_value        (value),
        .i_load         (load),
        .o_load_ack     (ack),
        .i_dp_mask      (dp_mask),
        .i_digit_enable (digit_enable),
        .i_lz_blank     (lz_blank),
        .o_digitselect  (sel),
        .o_segments     (seg)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
        end
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 32; i++) begin
            if (k % 32 != ph) tick();
        end
    endtask

    task automatic pulse_load(input logic [31:0] v, input logic [7:0] dp);
        value   = v;
        dp_mask = dp;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        while (ack !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(name, {31'd0, ack}, 32'd1);
    endtask

    // Output k edges after reset release reflects scan position k-1.
    function automatic logic [7:0] exp_sel(input int kk, input logic [7:0] en);
        int m, pos, d;
        m   = kk - 1;
        pos = m % 4;
        d   = (m / 4) % 8;
        if (pos == 0 || en[d] == 1'b0) return 8'hFF;
        return ~(8'h01 << d);
    endfunction

    function automatic logic [7:0] exp_seg(input int kk, input logic [7:0] en, input logic [7:0] code);
        int m, pos, d;
        m   = kk - 1;
        pos = m % 4;
        d   = (m / 4) % 8;
        if (pos == 0 || en[d] == 1'b0) return 8'hFF;
        return code;
    endfunction

    initial begin
        vecs[0]  = '{32'h1234_ABCD, 8'h01, 8'hFF, 1'b0, 0, 8'hFE, 8'h21};
        vecs[1]  = '{32'h1234_ABCD, 8'h01, 8'hFF, 1'b0, 3, 8'hF7, 8'h88};
        vecs[2]  = '{32'h1234_ABCD, 8'h01, 8'hFF, 1'b0, 7, 8'h7F, 8'hF9};
        vecs[3]  = '{32'h0000_00A0, 8'h00, 8'hFF, 1'b1, 1, 8'hFD, 8'h88};
        vecs[4]  = '{32'h0000_00A0, 8'h00, 8'hFF, 1'b1, 0, 8'hFE, 8'hC0};
        vecs[5]  = '{32'h0000_00A0, 8'h00, 8'hFF, 1'b1, 2, 8'hFF, 8'hFF};
        vecs[6]  = '{32'h0000_00A0, 8'h00, 8'hFF, 1'b0, 5, 8'hDF, 8'hC0};
        vecs[7]  = '{32'h89EF_0567, 8'h80, 8'hFF, 1'b0, 7, 8'h7F, 8'h00};
        vecs[8]  = '{32'h89EF_0567, 8'h80, 8'hFF, 1'b0, 4, 8'hEF, 8'h8E};
        vecs[9]  = '{32'h89EF_0567, 8'h80, 8'hFB, 1'b0, 2, 8'hFF, 8'hFF};
        vecs[10] = '{32'h89EF_0567, 8'h80, 8'hFB, 1'b0, 1, 8'hFD, 8'h82};
        vecs[11] = '{32'h0000_0000, 8'h00, 8'hFF, 1'b1, 0, 8'hFE, 8'hC0};

        rst = 1'b1; load = 1'b0; value = 32'h0; dp_mask = 8'h00;
        digit_enable = 8'hFF; lz_blank = 1'b0;
        tick();
        tick();
        check("rst_sel", {24'd0, sel}, 32'hFF);
        check("rst_seg", {24'd0, seg}, 32'hFF);
        check("rst_ack", {31'd0, ack}, 32'd0);
        rst = 1'b0;
        k   = 0;

        // Idle scan of the all-zero reset value.
        for (int i = 0; i < 40; i++) begin
            tick();
            check("scan_sel", {24'd0, sel}, {24'd0, exp_sel(k, 8'hFF)});
            check("scan_seg", {24'd0, seg}, {24'd0, exp_seg(k, 8'hFF, 8'hC0)});
            check("scan_ack", {31'd0, ack}, 32'd0);
        end

        // Handshake: old value stays until the frame boundary.
        pulse_load(32'h1234_ABCD, 8'h01);
        for (int i = 0; i < 40 && ack !== 1'b1; i++) begin
            check("hs_old_seg", {24'd0, seg}, {24'd0, exp_seg(k, 8'hFF, 8'hC0)});
            tick();
        end
        check("hs_ack", {31'd0, ack}, 32'd1);
        acks = 1;
        tick();
        check("hs_ack_pulse", {31'd0, ack}, 32'd0);
        check("hs_blank_sel", {24'd0, sel}, 32'hFF);
        tick();
        check("hs_d0_sel", {24'd0, sel}, 32'hFE);
        check("hs_d0_seg", {24'd0, seg}, 32'h21);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ack === 1'b1) acks++;
        end
        check("hs_ack_count", acks, 32'd1);

        // Double load inside one frame: latest wins, single ack.
        wait_phase(1);
        pulse_load(32'h1111_1111, 8'h00);
        tick();
        tick();
        pulse_load(32'h2222_2222, 8'h00);
        wait_ack("dbl_ack");
        acks = (ack === 1'b1) ? 1 : 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (ack === 1'b1) acks++;
            check("dbl_seg", {24'd0, seg}, {24'd0, exp_seg(k, 8'hFF, 8'hA4)});
        end
        check("dbl_ack_count", acks, 32'd1);

        // Table of single-digit expectations after each applied load.
        for (int t = 0; t < 12; t++) begin
            digit_enable = vecs[t].en;
            lz_blank     = vecs[t].lz;
            pulse_load(vecs[t].value, vecs[t].dp);
            wait_ack($sformatf("vec%0d_ack", t));
            repeat (1 + 4 * vecs[t].dig) tick();
            check($sformatf("vec%0d_blank", t), {24'd0, sel}, 32'hFF);
            tick();
            check($sformatf("vec%0d_sel", t), {24'd0, sel}, {24'd0, vecs[t].exp_sel});
            check($sformatf("vec%0d_seg", t), {24'd0, seg}, {24'd0, vecs[t].exp_seg});
        end

        // Disabled digit 2 over a full frame: slot timing unchanged.
        digit_enable = 8'hFB;
        lz_blank     = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            check("en_sel", {24'd0, sel}, {24'd0, exp_sel(k, 8'hFB)});
        end
        digit_enable = 8'hFF;

        // Load landing exactly on the digit 7 -> 0 wrap is applied at once.
        wait_phase(31);
        pulse_load(32'h5555_5555, 8'h00);
        check("bnd_ack", {31'd0, ack}, 32'd1);
        tick();
        check("bnd_ack_pulse", {31'd0, ack}, 32'd0);
        check("bnd_blank_sel", {24'd0, sel}, 32'hFF);
        tick();
        check("bnd_d0_sel", {24'd0, sel}, 32'hFE);
        check("bnd_d0_seg", {24'd0, seg}, 32'h92);

        // Reset mid-slot with a load pending.
        wait_phase(3);
        pulse_load(32'h7777_7777, 8'h00);
        wait_phase(10);
        check("pre_rst_sel", {24'd0, sel}, 32'hFB);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_sel", {24'd0, sel}, 32'hFF);
        check("async_rst_seg", {24'd0, seg}, 32'hFF);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        k   = 0;
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ack === 1'b1) acks++;
            check("post_rst_seg", {24'd0, seg}, {24'd0, exp_seg(k, 8'hFF, 8'hC0)});
        end
        check("post_rst_no_ack", acks, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
